router_stage40_ingress: RTL and testbench

//   Ingress buffer and framing checker for one router input port. It sits directly upstream of

---
 rtl/packet_types.sv | 25 ++
 rtl/router_flit_fifo.sv | 57 +++++
 rtl/router_stage40_ingress.sv | 100 ++++++++++
 tb/tb_router_stage40_ingress.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/packet_types.sv
// Shared flit-framing types for the router ingress path.
//   flit_type_e   : 2-bit flit type carried in the top bits of every flit
//   frame_state_e : HEAD..TAIL framing tracker state
//   get_flit_type : decodes the type field (caller passes flit[FLIT_W-1 -: 2])
package packet_types;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  // Type field width is fixed, so the decoder takes the type bits only and
  // stays independent of FLIT_W.
  function automatic flit_type_e get_flit_type(input logic [1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// Small synchronous FIFO for ingress flits.
//   clk, rst_n : clock, async active-low reset (clears storage, pointers, level)
//   push_i/din_i : write request and data (ignored while full)
//   pop_i        : read request (ignored while empty)
//   dout_o       : head entry, registered storage read, no bypass
//   level_o      : occupied entries; full_o / empty_o derived from it
module router_flit_fifo #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] din_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] dout_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DEPTH-1:0][FLIT_W-1:0] mem_q;
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]             level_q;
  logic                         do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);  // power-of-2 depth: natural wrap
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/router_stage40_ingress.sv
// Ingress buffer and HEAD..TAIL framing checker for one router input port.
//   in_flit/in_valid/in_ready    : link side handshake; in_ready = level != DEPTH
//   out_flit/out_valid/out_ready : stage50 side handshake from the FIFO head
//   out_is_head                  : head flit is HEAD or HEADTAIL
//   err_pulse                    : one cycle after an accepted flit is dropped
//   err_count                    : saturating drop count
//   fifo_level                   : occupied FIFO entries
module router_stage40_ingress
  import packet_types::*;
#(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4,
  parameter int ERR_W  = 8,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_head,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [LVL_W-1:0]  fifo_level
);

  frame_state_e     state_q, state_d;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;
  flit_type_e       in_type, head_type;
  logic             xfer, legal, push, drop, pop;
  logic             fifo_full, fifo_empty;

  assign in_ready = (fifo_level != LVL_W'(DEPTH));
  assign xfer     = in_valid & in_ready;
  assign in_type  = get_flit_type(in_flit[FLIT_W-1 -: 2]);

  // Legality and next framing state; only applied on an input transfer.
  always_comb begin
    legal   = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        legal = (in_type == HEAD) || (in_type == HEADTAIL);
        if (in_type == HEAD) state_d = IN_PKT;
      end
      IN_PKT: begin
        legal = (in_type == BODY) || (in_type == TAIL);
        if (in_type == TAIL) state_d = IDLE;
      end
      default: begin
        legal   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign push = xfer & legal;
  assign drop = xfer & ~legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (push) state_q <= state_d;
      err_pulse_q <= drop;
      if (drop && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

  router_flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (in_flit),
    .pop_i   (pop),
    .dout_o  (out_flit),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;
  assign head_type   = get_flit_type(out_flit[FLIT_W-1 -: 2]);
  // Gate with valid: the reset head reads as type HEAD.
  assign out_is_head = out_valid & ((head_type == HEAD) || (head_type == HEADTAIL));

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_router_stage40_ingress.sv
module tb_router_stage40_ingress;

  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic        clk, rst_n;
  logic [63:0] in_flit, out_flit;
  logic        in_valid, in_ready, out_valid, out_ready, out_is_head, err_pulse;
  logic [7:0]  err_count;
  logic [2:0]  fifo_level;

  router_stage40_ingress #(.FLIT_W(64), .DEPTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_head(out_is_head), .err_pulse(err_pulse), .err_count(err_count),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs = 0;
  logic [63:0] exp_q[$];
  int          seq = 1;
  bit          m_in_pkt = 1'b0;
  int          m_cnt = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("level", 64'(fifo_level), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_flit", out_flit, e);
        chk("out_is_head", 64'(out_is_head), 64'(e[63:62] == T_HEAD || e[63:62] == T_HT));
      end
    end
  end

  // Drive one flit; waits (bounded) for in_ready; updates the framing model.
  task automatic send(input logic [1:0] t);
    bit legal;
    int budget;
    in_flit  = {t, 62'(seq)};
    seq++;
    in_valid = 1'b1;
    budget   = 0;
    @(negedge clk);
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    legal = m_in_pkt ? (t == T_BODY || t == T_TAIL) : (t == T_HEAD || t == T_HT);
    if (legal) begin
      exp_q.push_back(in_flit);
      if (t == T_HEAD) m_in_pkt = 1'b1;
      else if (t == T_TAIL) m_in_pkt = 1'b0;
    end else if (m_cnt != 255) m_cnt++;
    #1;
    in_valid = 1'b0;
    chk("err_pulse", 64'(err_pulse), 64'(!legal));
    chk("err_count", 64'(err_count), 64'(m_cnt));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    chk("err_pulse_idle", 64'(err_pulse), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", out_flit, 64'd0);
    chk("rst_out_is_head", 64'(out_is_head), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;

    // 1: basic packet, visible one cycle after its push
    send(T_HEAD);
    chk("t1_latency", 64'(out_valid), 64'd1);
    send(T_BODY);
    send(T_TAIL);
    drain();

    // 2: backpressure, full FIFO holds off the 5th flit
    out_ready = 1'b0;
    send(T_HEAD); send(T_BODY); send(T_BODY); send(T_BODY);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    chk("t2_level_full", 64'(fifo_level), 64'd4);
    in_flit = {T_TAIL, 62'd0}; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_wait", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(T_TAIL);
    drain();

    // 3: stray BODY/TAIL in IDLE are dropped
    send(T_BODY);
    send(T_TAIL);
    drain();

    // 4: HEAD inside a packet dropped; HEADTAIL afterwards; IDLE proven by a BODY drop
    send(T_HEAD); send(T_HEAD); send(T_TAIL);
    send(T_HT);
    send(T_BODY);
    drain();

    // 5: sustained push+pop around a full FIFO across pointer wrap
    out_ready = 1'b0;
    send(T_HEAD); send(T_BODY); send(T_BODY); send(T_BODY);
    out_ready = 1'b1;
    repeat (10) send(T_BODY);
    send(T_TAIL);
    drain();

    // 6: drop counter saturation, then async reset mid-packet
    repeat (260) send(T_BODY);
    chk("t6_sat", 64'(err_count), 64'd255);
    out_ready = 1'b0;
    send(T_HEAD); send(T_BODY);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    chk("t6_rst_err_count", 64'(err_count), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete(); m_in_pkt = 1'b0; m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send(T_BODY);
    send(T_HT);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
